// File: rtl/alu_op_sequencer.sv
// Sequences one or two ALU passes per operation (byte ops, INCW/DECW word ops, two-nibble DA),
// chains intermediate flags between passes and owns the architectural FLAGS register.
module alu_op_sequencer #(
  parameter logic [7:0] FLAGS_RESET = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [4:0]  mode_in,
  input  logic [15:0] a_in,
  input  logic [7:0]  b_in,
  input  logic        flags_load,
  input  logic [7:0]  flags_din,
  output logic [4:0]  alu_mode,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [7:0]  alu_flags,
  input  logic [7:0]  alu_out,
  input  logic [7:0]  alu_flags_o,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        result_we,
  output logic [7:0]  flags
);

  // ALU mode encodings shared with the ALU's decode table.
  localparam logic [4:0] ALU2_TCM          = 5'h06;
  localparam logic [4:0] ALU2_TM           = 5'h07;
  localparam logic [4:0] ALU2_CP           = 5'h08;
  localparam logic [4:0] ALU1_LD           = 5'h10;
  localparam logic [4:0] ALU1_INC          = 5'h11;
  localparam logic [4:0] ALU1_DEC          = 5'h12;
  localparam logic [4:0] ALU1_DA           = 5'h13;
  localparam logic [4:0] ALU1_INCW         = 5'h14;
  localparam logic [4:0] ALU1_DECW         = 5'h15;
  localparam logic [4:0] ALU1_INCW_UPPER_0 = 5'h16;
  localparam logic [4:0] ALU1_DA_H         = 5'h17;

  typedef enum logic [1:0] {S_IDLE, S_P1, S_P2} state_e;
  typedef enum logic [1:0] {OP_BYTE = 2'd0, OP_INCW = 2'd1, OP_DECW = 2'd2, OP_DA = 2'd3} op_e;

  state_e      state;
  op_e         op_q;
  logic [4:0]  mode_q;
  logic [15:0] a_q;
  logic [7:0]  b_q;
  logic [7:0]  lo_q;
  logic [7:0]  tf_q;
  logic        carry_q;
  logic        flags_only;

  assign flags_only = (mode_q == ALU2_CP) || (mode_q == ALU2_TM) || (mode_q == ALU2_TCM);

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    alu_mode  = ALU1_LD;
    alu_a     = 8'h00;
    alu_b     = 8'h00;
    alu_flags = flags;
    case (state)
      S_P1: begin
        alu_a = a_q[7:0];
        case (op_q)
          OP_BYTE: begin
            alu_mode = mode_q;
            alu_b    = b_q;
          end
          OP_INCW: alu_mode = ALU1_INC;
          OP_DECW: alu_mode = ALU1_DEC;
          OP_DA:   alu_mode = ALU1_DA;
          default: alu_mode = ALU1_LD;
        endcase
      end
      S_P2: begin
        alu_flags = tf_q;
        case (op_q)
          OP_INCW: begin
            alu_mode = carry_q ? ALU1_INCW : ALU1_INCW_UPPER_0;
            alu_a    = a_q[15:8];
          end
          // Without a borrow the high byte passes through, chaining Z and clearing V.
          OP_DECW: begin
            alu_mode = carry_q ? ALU1_DECW : ALU1_INCW_UPPER_0;
            alu_a    = a_q[15:8];
          end
          OP_DA: begin
            alu_mode = ALU1_DA_H;
            alu_a    = lo_q;
          end
          default: alu_mode = ALU1_LD;
        endcase
      end
      default: ;
    endcase
  end

  // NOTE: operand/intermediate registers are reset too, so nothing X can reach the ALU after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      op_q      <= OP_BYTE;
      mode_q    <= 5'h00;
      a_q       <= 16'h0000;
      b_q       <= 8'h00;
      lo_q      <= 8'h00;
      tf_q      <= 8'h00;
      carry_q   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result_we <= 1'b0;
      result    <= 16'h0000;
      flags     <= FLAGS_RESET;
    end else begin
      // NOTE: non-blocking assignments keep every register reading pre-edge values.
      done      <= 1'b0;
      result_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (flags_load) flags <= flags_din;
          if (start) begin
            op_q   <= op_e'(op);
            mode_q <= mode_in;
            a_q    <= a_in;
            b_q    <= b_in;
            busy   <= 1'b1;
            state  <= S_P1;
          end
        end
        S_P1: begin
          lo_q    <= alu_out;
          tf_q    <= alu_flags_o;
          carry_q <= (op_q == OP_DECW) ? (alu_out == 8'hFF) : (alu_out == 8'h00);
          if (op_q == OP_BYTE) begin
            flags     <= alu_flags_o;
            result    <= {8'h00, alu_out};
            done      <= 1'b1;
            result_we <= !flags_only;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end else begin
            state <= S_P2;
          end
        end
        S_P2: begin
          flags     <= alu_flags_o;
          // DA_H leaves its low nibble undefined; the adjusted low nibble comes from pass 1.
          result    <= (op_q == OP_DA) ? {8'h00, alu_out[7:4], lo_q[3:0]} : {alu_out, lo_q};
          done      <= 1'b1;
          result_we <= 1'b1;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
